adv7393_line_fetch_sched: RTL and testbench

// - Schedules per-line DDR reads for the ADV7393 output path: on each active-line start from the timing generator,

---
 rtl/adv7393_line_fetch_sched_if.sv | 29 ++
 rtl/adv7393_line_fetch_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_adv7393_line_fetch_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adv7393_line_fetch_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : adv7393_line_fetch_sched_if
// Brief    : Read-command handshake between the line fetch scheduler and the
//            AXI read mover feeding the pixel line buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface adv7393_line_fetch_sched_if #(
    parameter int ADDR_W  = 32,
    parameter int BEATS_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [BEATS_W-1:0] cmd_beats;
    logic               cmd_buf;
    logic               fetch_done;

    modport master (
        output cmd_valid, cmd_addr, cmd_beats, cmd_buf,
        input  cmd_ready, fetch_done
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_beats, cmd_buf,
        output cmd_ready, fetch_done
    );
endinterface
`default_nettype wire

// File: rtl/adv7393_line_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module   : adv7393_line_fetch_sched
// Brief    : Issues one DDR read per active line for the next line into the
//            idle half of a 2-deep line ping-pong buffer; owns fb_sel,
//            vertical centring window, blanking and underrun detection.
// Revision : 1.0 - initial release
// ============================================================================
module adv7393_line_fetch_sched #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 10,
    parameter int BEATS_W    = 16,
    parameter int PIX_PER_BT = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                enable,
    input  wire logic [ADDR_W-1:0]   cfg_base,
    input  wire logic [ADDR_W-1:0]   cfg_line_step,
    input  wire logic [LINE_W-1:0]   cfg_lines,
    input  wire logic [15:0]         cfg_line_len,
    input  wire logic [LINE_W-1:0]   std_act_lines,
    input  wire logic                frame_start,
    input  wire logic                line_start,
    input  wire logic [LINE_W-1:0]   line_num,
    input  wire logic                swap_req,
    adv7393_line_fetch_sched_if.master cmd,
    output logic                     disp_buf,
    output logic                     disp_blank,
    output logic                     fb_sel,
    output logic                     underrun,
    output logic                     busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_req  = 2'd2;
    localparam logic [1:0] c_st_wait = 2'd3;

    localparam int c_beat_shift = $clog2(PIX_PER_BT);

    // Window is centred when the stored frame fits, otherwise cropped to the standard.
    function automatic logic [LINE_W-1:0] f_win_start(input logic [LINE_W-1:0] lines,
                                                      input logic [LINE_W-1:0] act);
        if (lines > act) return '0;
        return (act - lines) >> 1;
    endfunction

    function automatic logic [LINE_W-1:0] f_win_stop(input logic [LINE_W-1:0] lines,
                                                     input logic [LINE_W-1:0] act);
        if (lines > act) return act;
        return f_win_start(lines, act) + lines;
    endfunction

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_step;
    logic [LINE_W-1:0]   r_lines;
    logic [15:0]         r_len;
    logic [LINE_W-1:0]   r_act;
    logic                r_en;
    logic                r_fb_sel;
    logic                r_swap_pend;
    logic                r_pf_pend;
    logic                r_stale;
    logic                r_rst_done;
    logic [LINE_W-1:0]   r_req_line;
    logic [LINE_W-1:0]   r_req_k;
    logic                r_req_buf;
    logic                r_cmd_valid;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [BEATS_W-1:0]  r_cmd_beats;
    logic                r_cmd_buf;
    logic                r_disp_buf;
    logic                r_disp_blank;
    logic                r_underrun;
    logic [1:0]          r_ok_valid;
    logic [1:0][LINE_W-1:0] r_ok_line;

    logic [LINE_W-1:0]   w_win_start;
    logic [LINE_W-1:0]   w_win_stop;
    logic [LINE_W-1:0]   w_in_win_start;
    logic                w_in_nonempty;
    logic                w_pf_ok;
    logic                w_cur_active;
    logic [LINE_W:0]     w_nxt_line;
    logic                w_nxt_active;
    logic                w_disp_sel;
    logic                w_line_ok;
    logic                w_busy;
    logic                w_done_now;
    logic [ADDR_W-1:0]   w_frame_off;
    logic [ADDR_W-1:0]   w_addr;
    logic [BEATS_W-1:0]  w_beats;

    assign w_win_start    = f_win_start(r_lines, r_act);
    assign w_win_stop     = f_win_stop(r_lines, r_act);
    assign w_in_win_start = f_win_start(cfg_lines, std_act_lines);
    assign w_in_nonempty  = f_win_stop(cfg_lines, std_act_lines) > w_in_win_start;
    assign w_pf_ok        = r_en && (w_win_stop > w_win_start);

    assign w_cur_active = (line_num >= w_win_start) && (line_num < w_win_stop);
    assign w_nxt_line   = {1'b0, line_num} + (LINE_W+1)'(1);
    assign w_nxt_active = (w_nxt_line >= {1'b0, w_win_start}) && (w_nxt_line < {1'b0, w_win_stop});
    assign w_disp_sel   = line_num[0] ^ w_win_start[0];
    assign w_line_ok    = r_ok_valid[w_disp_sel] && (r_ok_line[w_disp_sel] == line_num);
    assign w_busy       = (r_state != c_st_idle);
    assign w_done_now   = (r_state == c_st_wait) && cmd.fetch_done;

    assign w_frame_off = r_fb_sel ? ({{(ADDR_W-LINE_W){1'b0}}, r_lines} * r_step) : '0;
    assign w_addr      = r_base + w_frame_off + ({{(ADDR_W-LINE_W){1'b0}}, r_req_k} * r_step);
    assign w_beats     = BEATS_W'(r_len >> c_beat_shift);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_base       <= '0;
            r_step       <= '0;
            r_lines      <= '0;
            r_len        <= '0;
            r_act        <= '0;
            r_en         <= 1'b0;
            r_fb_sel     <= 1'b0;
            r_swap_pend  <= 1'b0;
            r_pf_pend    <= 1'b0;
            r_stale      <= 1'b0;
            r_rst_done   <= 1'b0;
            r_req_line   <= '0;
            r_req_k      <= '0;
            r_req_buf    <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_beats  <= '0;
            r_cmd_buf    <= 1'b0;
            r_disp_buf   <= 1'b0;
            r_disp_blank <= 1'b0;
            r_underrun   <= 1'b0;
            r_ok_valid   <= '0;
            r_ok_line    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (frame_start) begin
                        if (enable && w_in_nonempty) begin
                            r_req_line <= w_in_win_start;
                            r_req_k    <= '0;
                            r_req_buf  <= 1'b0;
                            r_state    <= c_st_calc;
                        end
                    end else if (line_start) begin
                        if (r_en && w_nxt_active) begin
                            r_req_line <= w_nxt_line[LINE_W-1:0];
                            r_req_k    <= w_nxt_line[LINE_W-1:0] - w_win_start;
                            r_req_buf  <= w_nxt_line[0] ^ w_win_start[0];
                            r_state    <= c_st_calc;
                        end
                    end else if (r_pf_pend) begin
                        r_pf_pend <= 1'b0;
                        if (w_pf_ok) begin
                            r_req_line <= w_win_start;
                            r_req_k    <= '0;
                            r_req_buf  <= 1'b0;
                            r_state    <= c_st_calc;
                        end
                    end
                end
                c_st_calc: begin
                    r_cmd_addr             <= w_addr;
                    r_cmd_beats            <= w_beats;
                    r_cmd_buf              <= r_req_buf;
                    r_cmd_valid            <= 1'b1;
                    r_ok_valid[r_req_buf]  <= 1'b0;
                    r_state                <= c_st_req;
                end
                c_st_req: begin
                    if (cmd.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (cmd.fetch_done) begin
                        if (!r_stale) begin
                            r_ok_valid[r_cmd_buf] <= 1'b1;
                            r_ok_line[r_cmd_buf]  <= r_req_line;
                        end
                        r_stale <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // Placed after the FSM so a new frame wins over a same-cycle completion.
            if (frame_start) begin
                r_base      <= cfg_base;
                r_step      <= cfg_line_step;
                r_lines     <= cfg_lines;
                r_len       <= cfg_line_len;
                r_act       <= std_act_lines;
                r_en        <= enable;
                r_swap_pend <= swap_req;
                if (r_swap_pend) r_fb_sel <= ~r_fb_sel;
                r_ok_valid  <= '0;
                r_pf_pend   <= w_busy;
                r_stale     <= w_busy && !w_done_now;
            end else if (swap_req) begin
                r_swap_pend <= 1'b1;
            end

            r_rst_done <= 1'b1;
            if (!r_rst_done) r_disp_blank <= 1'b1;

            if (line_start) begin
                r_disp_buf   <= w_disp_sel;
                r_disp_blank <= !(r_en && w_cur_active && w_line_ok) || w_busy;
                if (w_busy) r_underrun <= 1'b1;
            end
        end
    end

    assign cmd.cmd_valid = r_cmd_valid;
    assign cmd.cmd_addr  = r_cmd_addr;
    assign cmd.cmd_beats = r_cmd_beats;
    assign cmd.cmd_buf   = r_cmd_buf;

    assign disp_buf   = r_disp_buf;
    assign disp_blank = r_disp_blank;
    assign fb_sel     = r_fb_sel;
    assign underrun   = r_underrun;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_adv7393_line_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_adv7393_line_fetch_sched
// Brief    : Self-checking bench for the ADV7393 line fetch scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adv7393_line_fetch_sched;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] beats;
        logic        b;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable;
    logic [31:0] cfg_base;
    logic [31:0] cfg_line_step;
    logic [9:0]  cfg_lines;
    logic [15:0] cfg_line_len;
    logic [9:0]  std_act_lines;
    logic        frame_start;
    logic        line_start;
    logic [9:0]  line_num;
    logic        swap_req;
    logic        disp_buf;
    logic        disp_blank;
    logic        fb_sel;
    logic        underrun;
    logic        busy;

    bit   auto_mover = 1'b0;
    logic a_ready = 1'b0, a_done = 1'b0, m_ready = 1'b0, m_done = 1'b0;
    cmd_t cmd_log[$];

    int checks = 0;
    int errors = 0;
    int m_fb   = 0;
    bit m_swap_pend = 1'b0;

    adv7393_line_fetch_sched_if #(.ADDR_W(32), .BEATS_W(16)) bus ();

    assign bus.cmd_ready  = auto_mover ? a_ready : m_ready;
    assign bus.fetch_done = auto_mover ? a_done  : m_done;

    adv7393_line_fetch_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg_base      (cfg_base),
        .cfg_line_step (cfg_line_step),
        .cfg_lines     (cfg_lines),
        .cfg_line_len  (cfg_line_len),
        .std_act_lines (std_act_lines),
        .frame_start   (frame_start),
        .line_start    (line_start),
        .line_num      (line_num),
        .swap_req      (swap_req),
        .cmd           (bus),
        .disp_buf      (disp_buf),
        .disp_blank    (disp_blank),
        .fb_sel        (fb_sel),
        .underrun      (underrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Mover model: bounded random accept delay and completion delay, logs commands.
    initial begin : mover
        int cnt;
        int rdly;
        bit waiting;
        cnt = 0; rdly = -1; waiting = 1'b0;
        forever begin
            @(negedge clk);
            a_ready = 1'b0;
            a_done  = 1'b0;
            if (!auto_mover || !rst_n) begin
                waiting = 1'b0;
                rdly    = -1;
            end else if (waiting) begin
                if (cnt == 0) begin
                    a_done  = 1'b1;
                    waiting = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (bus.cmd_valid) begin
                if (rdly < 0) rdly = $urandom_range(0, 2);
                if (rdly == 0) begin
                    a_ready = 1'b1;
                    cmd_log.push_back({bus.cmd_addr, bus.cmd_beats, bus.cmd_buf});
                    waiting = 1'b1;
                    cnt     = $urandom_range(0, 3);
                    rdly    = -1;
                end else begin
                    rdly--;
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic int ws_of(int lines, int act);
        return (lines > act) ? 0 : (act - lines) / 2;
    endfunction

    function automatic int stop_of(int lines, int act);
        return (lines > act) ? act : ws_of(lines, act) + lines;
    endfunction

    function automatic cmd_t mk_cmd(logic [31:0] base, logic [31:0] step, int lines,
                                    logic [15:0] len, int fb, int k);
        cmd_t c;
        c.addr  = base + ((fb != 0) ? 32'(lines) * step : 32'd0) + 32'(k) * step;
        c.beats = len >> 2;
        c.b     = 1'(k & 1);
        return c;
    endfunction

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame(bit swap);
        frame_start = 1'b1;
        swap_req    = swap;
        tick();
        frame_start = 1'b0;
        swap_req    = 1'b0;
    endtask

    task automatic line_pulse(int n);
        line_num   = 10'(n);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic complete_cmd();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        m_done  = 1'b1;
        tick();
        m_done  = 1'b0;
    endtask

    task automatic set_spec_cfg(logic [31:0] base);
        cfg_base      = base;
        cfg_line_step = 32'h1000;
        cfg_lines     = 10'd480;
        std_act_lines = 10'd576;
        cfg_line_len  = 16'd640;
        enable        = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
        checks++; if (bus.cmd_addr !== 32'h0) begin errors++; $display("FAIL reset_cmd_addr: got %h want 0", bus.cmd_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (disp_blank !== 1'b0) begin errors++; $display("FAIL reset_disp_blank: got %b want 0", disp_blank); end
        checks++; if ({fb_sel, underrun} !== 2'b00) begin errors++; $display("FAIL reset_fb_underrun: got %b want 00", {fb_sel, underrun}); end
        rst_n = 1'b1;
        tick();
        checks++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL post_reset_blank: got %b want 1", disp_blank); end
        m_fb = 0; m_swap_pend = 1'b0;
    endtask

    task automatic test_basic_frame();
        set_spec_cfg(32'h10000);
        pulse_frame(1'b0);
        tick();
        checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL prefetch_valid: got %b want 1", bus.cmd_valid); end
        checks++; if (bus.cmd_addr !== 32'h10000) begin errors++; $display("FAIL prefetch_addr: got %h want 00010000", bus.cmd_addr); end
        checks++; if (bus.cmd_beats !== 16'd160) begin errors++; $display("FAIL prefetch_beats: got %0d want 160", bus.cmd_beats); end
        checks++; if (bus.cmd_buf !== 1'b0) begin errors++; $display("FAIL prefetch_buf: got %b want 0", bus.cmd_buf); end
        complete_cmd();
        line_pulse(47);
        checks++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL line47_blank: got %b want 1", disp_blank); end
        tick();
        checks++; if ({bus.cmd_valid, bus.cmd_addr, bus.cmd_buf} !== {1'b1, 32'h10000, 1'b0}) begin
            errors++; $display("FAIL line47_cmd: got v%b a%h b%b want v1 a00010000 b0", bus.cmd_valid, bus.cmd_addr, bus.cmd_buf);
        end
        complete_cmd();
        line_pulse(48);
        checks++; if ({disp_blank, disp_buf} !== 2'b00) begin errors++; $display("FAIL line48_disp: got blank%b buf%b want blank0 buf0", disp_blank, disp_buf); end
        tick();
        checks++; if ({bus.cmd_valid, bus.cmd_addr, bus.cmd_buf} !== {1'b1, 32'h11000, 1'b1}) begin
            errors++; $display("FAIL line48_cmd: got v%b a%h b%b want v1 a00011000 b1", bus.cmd_valid, bus.cmd_addr, bus.cmd_buf);
        end
        complete_cmd();
        line_pulse(527);
        tick(3);
        checks++; if ({busy, bus.cmd_valid} !== 2'b00) begin errors++; $display("FAIL line527_no_cmd: got busy%b valid%b want 00", busy, bus.cmd_valid); end
        line_pulse(528);
        checks++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL line528_blank: got %b want 1", disp_blank); end
        tick(2);
    endtask

    task automatic test_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        pulse_frame(1'b0);
        tick();
        checks++; if (fb_sel !== 1'b1) begin errors++; $display("FAIL swap_fb: got %b want 1", fb_sel); end
        checks++; if (bus.cmd_addr !== 32'h1F0000) begin errors++; $display("FAIL swap_addr: got %h want 001f0000", bus.cmd_addr); end
        complete_cmd();
        pulse_frame(1'b1);
        tick();
        checks++; if ({fb_sel, bus.cmd_addr} !== {1'b1, 32'h1F0000}) begin errors++; $display("FAIL coincident_swap: got fb%b a%h want fb1 a001f0000", fb_sel, bus.cmd_addr); end
        complete_cmd();
        pulse_frame(1'b0);
        tick();
        checks++; if ({fb_sel, bus.cmd_addr} !== {1'b0, 32'h10000}) begin errors++; $display("FAIL deferred_swap: got fb%b a%h want fb0 a00010000", fb_sel, bus.cmd_addr); end
        complete_cmd();
        m_fb = 0; m_swap_pend = 1'b0;
    endtask

    task automatic test_underrun();
        pulse_frame(1'b0);
        tick(11);
        checks++; if ({bus.cmd_valid, bus.cmd_addr, bus.cmd_beats} !== {1'b1, 32'h10000, 16'd160}) begin
            errors++; $display("FAIL stall_hold: got v%b a%h n%0d want v1 a00010000 n160", bus.cmd_valid, bus.cmd_addr, bus.cmd_beats);
        end
        line_pulse(48);
        checks++; if ({underrun, disp_blank} !== 2'b11) begin errors++; $display("FAIL underrun_flag: got u%b blank%b want u1 blank1", underrun, disp_blank); end
        checks++; if ({bus.cmd_valid, bus.cmd_addr, bus.cmd_buf} !== {1'b1, 32'h10000, 1'b0}) begin
            errors++; $display("FAIL underrun_cmd_stable: got v%b a%h b%b want v1 a00010000 b0", bus.cmd_valid, bus.cmd_addr, bus.cmd_buf);
        end
        complete_cmd();
        tick(3);
        checks++; if ({busy, underrun} !== 2'b01) begin errors++; $display("FAIL underrun_no_queue: got busy%b u%b want busy0 u1", busy, underrun); end
    endtask

    task automatic test_frame_during_fetch();
        bit seen;
        pulse_frame(1'b0);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        set_spec_cfg(32'h40000);
        pulse_frame(1'b0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (bus.cmd_valid === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++; if ({seen, bus.cmd_addr, bus.cmd_buf} !== {1'b1, 32'h40000, 1'b0}) begin
            errors++; $display("FAIL late_prefetch: got seen%b a%h b%b want seen1 a00040000 b0", seen, bus.cmd_addr, bus.cmd_buf);
        end
        if (seen) complete_cmd();
        set_spec_cfg(32'h10000);
    endtask

    task automatic test_reset_mid_req();
        pulse_frame(1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if ({bus.cmd_valid, bus.cmd_addr, bus.cmd_beats, bus.cmd_buf} !== 50'h0) begin
            errors++; $display("FAIL rst_mid_cmd: got v%b a%h n%0d b%b want all 0", bus.cmd_valid, bus.cmd_addr, bus.cmd_beats, bus.cmd_buf);
        end
        checks++; if ({busy, underrun, fb_sel, disp_blank, disp_buf} !== 5'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got %b want 00000", {busy, underrun, fb_sel, disp_blank, disp_buf});
        end
        rst_n = 1'b1;
        tick(2);
        m_fb = 0; m_swap_pend = 1'b0;
    endtask

    task automatic test_random_frames();
        cmd_t exp_q[$];
        auto_mover = 1'b1;
        for (int f = 0; f < 6; f++) begin
            logic [31:0] base, step;
            logic [15:0] len;
            int lines, act, ws, stop;
            bit en, pre_swap, co_swap, exp_blank;
            base     = $urandom;
            step     = 32'($urandom_range(0, 32'hFFFF)) << 4;
            lines    = $urandom_range(0, 130);
            act      = $urandom_range(8, 120);
            len      = 16'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            pre_swap = 1'($urandom_range(0, 1));
            co_swap  = 1'($urandom_range(0, 1));
            ws       = ws_of(lines, act);
            stop     = stop_of(lines, act);
            if (pre_swap) begin
                swap_req = 1'b1;
                tick();
                swap_req = 1'b0;
                m_swap_pend = 1'b1;
            end
            if (m_swap_pend) m_fb ^= 1;
            m_swap_pend = co_swap;
            cfg_base = base; cfg_line_step = step; cfg_lines = 10'(lines);
            std_act_lines = 10'(act); cfg_line_len = len; enable = en;
            cmd_log.delete();
            exp_q.delete();
            pulse_frame(co_swap);
            cfg_base = $urandom; cfg_line_step = $urandom; cfg_lines = 10'($urandom);
            std_act_lines = 10'($urandom); cfg_line_len = 16'($urandom); enable = 1'($urandom);
            if (en && stop > ws) exp_q.push_back(mk_cmd(base, step, lines, len, m_fb, 0));
            tick(12);
            for (int n = 0; n < act; n++) begin
                line_pulse(n);
                exp_blank = !(en && n >= ws && n < stop);
                checks++; if (disp_blank !== exp_blank) begin errors++; $display("FAIL rnd_blank f%0d line%0d: got %b want %b", f, n, disp_blank, exp_blank); end
                checks++; if (disp_buf !== 1'((n ^ ws) & 1)) begin errors++; $display("FAIL rnd_buf f%0d line%0d: got %b want %b", f, n, disp_buf, 1'((n ^ ws) & 1)); end
                if (en && n + 1 >= ws && n + 1 < stop) exp_q.push_back(mk_cmd(base, step, lines, len, m_fb, n + 1 - ws));
                tick(11);
            end
            tick(12);
            checks++; if (cmd_log.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_cmd_count f%0d: got %0d want %0d", f, cmd_log.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
                checks++; if (cmd_log[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_cmd f%0d #%0d: got %h want %h", f, i, cmd_log[i], exp_q[i]); end
            end
            checks++; if ({fb_sel, underrun} !== {1'(m_fb), 1'b0}) begin errors++; $display("FAIL rnd_fb_underrun f%0d: got %b want %b", f, {fb_sel, underrun}, {1'(m_fb), 1'b0}); end
        end
        auto_mover = 1'b0;
    endtask

    initial begin
        enable = 1'b0; cfg_base = '0; cfg_line_step = '0; cfg_lines = '0;
        cfg_line_len = '0; std_act_lines = '0; frame_start = 1'b0;
        line_start = 1'b0; line_num = '0; swap_req = 1'b0;
        test_reset();
        test_basic_frame();
        test_swap();
        test_underrun();
        test_frame_during_fetch();
        test_reset_mid_req();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
